// File: rtl/op4_dispatch_if.sv
// Signal bundle between the command producer, operation4 and the result consumer.
// The dispatcher uses the slave view; the surrounding system uses the master view.
interface op4_dispatch_if;
  logic [31:0] in_data;
  logic        in_STB;
  logic        in_BUSY;
  logic [15:0] op_a, op_b, op_c, op_d;
  logic        op4_input_STB;
  logic        op4_BUSY;
  logic [15:0] op4_result;
  logic        op4_output_STB;
  logic        op4_output_module_BUSY;
  logic [15:0] result;
  logic        result_err;
  logic        result_STB;
  logic        result_BUSY;
  logic [15:0] done_count;

  modport slave (
    input  in_data, in_STB, op4_BUSY, op4_result, op4_output_STB, result_BUSY,
    output in_BUSY, op_a, op_b, op_c, op_d, op4_input_STB, op4_output_module_BUSY,
           result, result_err, result_STB, done_count
  );
  modport master (
    output in_data, in_STB, op4_BUSY, op4_result, op4_output_STB, result_BUSY,
    input  in_BUSY, op_a, op_b, op_c, op_d, op4_input_STB, op4_output_module_BUSY,
           result, result_err, result_STB, done_count
  );
endinterface

// File: rtl/op4_dispatch.sv
// Sequencer feeding four 16-bit operands to operation4 and returning its sum,
// with a bounded wait that aborts with an error result.
module op4_dispatch #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  op4_dispatch_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, WAIT_FREE, ISSUE, WAIT_RES, RETURN} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_nx;
  logic              in_busy_q, in_busy_nx;
  logic              stb_q, stb_nx;
  logic              omb_q, omb_nx;
  logic              res_stb_q, res_stb_nx;
  logic              err_q, err_nx;
  logic [15:0]       res_q, res_nx;
  logic [15:0]       cnt_q, cnt_nx;
  logic [15:0]       done_q, done_nx;
  logic [3:0][15:0]  op_q, op_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_busy_q <= 1'b0;
      stb_q     <= 1'b0;
      omb_q     <= 1'b1;
      res_stb_q <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_nx;
      in_busy_q <= in_busy_nx;
      stb_q     <= stb_nx;
      omb_q     <= omb_nx;
      res_stb_q <= res_stb_nx;
      err_q     <= err_nx;
      res_q     <= res_nx;
      cnt_q     <= cnt_nx;
      done_q    <= done_nx;
      op_q      <= op_nx;
    end
  end

  always_comb begin
    state_nx   = state_q;
    in_busy_nx = in_busy_q;
    stb_nx     = stb_q;
    omb_nx     = omb_q;
    res_stb_nx = res_stb_q;
    err_nx     = err_q;
    res_nx     = res_q;
    cnt_nx     = cnt_q;
    done_nx    = done_q;
    op_nx      = op_q;
    case (state_q)
      IDLE: begin
        if (bus.in_STB && !in_busy_q) begin
          op_nx[0]   = bus.in_data[15:0];
          op_nx[1]   = bus.in_data[31:16];
          in_busy_nx = 1'b1;
          state_nx   = LOAD_HI;
        end
      end
      LOAD_HI: begin
        // One-cycle busy pulse separates the two words of a command.
        if (in_busy_q) begin
          in_busy_nx = 1'b0;
        end else if (bus.in_STB) begin
          op_nx[2]   = bus.in_data[15:0];
          op_nx[3]   = bus.in_data[31:16];
          in_busy_nx = 1'b1;
          state_nx   = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        in_busy_nx = 1'b1;
        if (!bus.op4_BUSY) begin
          stb_nx   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.op4_BUSY) begin
          stb_nx   = 1'b0;
          omb_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the last counted cycle still wins over the abort.
        if (bus.op4_output_STB) begin
          res_nx     = bus.op4_result;
          err_nx     = 1'b0;
          omb_nx     = 1'b1;
          res_stb_nx = 1'b1;
          state_nx   = RETURN;
        end else if (cnt_q == TO_LAST) begin
          res_nx     = 16'hFFFF;
          err_nx     = 1'b1;
          omb_nx     = 1'b1;
          res_stb_nx = 1'b1;
          state_nx   = RETURN;
        end else begin
          cnt_nx = cnt_q + 16'd1;
        end
      end
      RETURN: begin
        if (res_stb_q && !bus.result_BUSY) begin
          res_stb_nx = 1'b0;
          in_busy_nx = 1'b0;
          if (!err_q) done_nx = done_q + 16'd1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_BUSY                = in_busy_q;
  assign bus.op_a                   = op_q[0];
  assign bus.op_b                   = op_q[1];
  assign bus.op_c                   = op_q[2];
  assign bus.op_d                   = op_q[3];
  assign bus.op4_input_STB          = stb_q;
  assign bus.op4_output_module_BUSY = omb_q;
  assign bus.result                 = res_q;
  assign bus.result_err             = err_q;
  assign bus.result_STB             = res_stb_q;
  assign bus.done_count             = done_q;
endmodule

// File: tb/tb_op4_dispatch.sv
// Randomized bench for op4_dispatch: the bench plays producer, operation4 and
// consumer, and predicts each result, latency and counter value from the rules.
module tb_op4_dispatch;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  op4_dispatch_if bus();
  op4_dispatch #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;
  logic [15:0] done_m = '0;
  bit stub_stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word and count the edges until it transfers (0 = never).
  task automatic send_word(input logic [31:0] w, output int n);
    bus.in_STB  = 1'b1;
    bus.in_data = w;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      if (!bus.in_BUSY) begin
        tick();
        n = i;
        break;
      end
      tick();
    end
    bus.in_STB = 1'b0;
  endtask

  task automatic chk_reset_state;
    chk("rst_in_busy", bus.in_BUSY, 0);
    chk("rst_op4_stb", bus.op4_input_STB, 0);
    chk("rst_omb", bus.op4_output_module_BUSY, 1);
    chk("rst_res_stb", bus.result_STB, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_err", bus.result_err, 0);
    chk("rst_ops", {bus.op_d, bus.op_c, bus.op_b, bus.op_a}, 0);
    chk("rst_ops_hi", 32'(({bus.op_d, bus.op_c, bus.op_b, bus.op_a}) >> 64), 0);
    chk("rst_done", bus.done_count, 0);
  endtask

  // Drive one command up to WAIT_RES entry; hold = cycles operation4 stays busy first.
  task automatic issue(input logic [31:0] w0, input logic [31:0] w1, input int hold_in);
    int n;
    int hold;
    hold = hold_in;
    send_word(w0, n); chk("acc0_edges", n, 1);
    send_word(w1, n); chk("acc1_edges", n, 2);
    chk("wf_stb_low", bus.op4_input_STB, 0);
    chk("wf_in_busy", bus.in_BUSY, 1);
    if (stub_stuck && hold == 0) hold = 1;
    if (hold > 0) bus.op4_BUSY = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("wf_hold", bus.op4_input_STB, 0);
    end
    bus.op4_BUSY = 1'b0;
    stub_stuck = 1'b0;
    tick();
    chk("stb_rise", bus.op4_input_STB, 1);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      tick();
      chk("stb_hold", bus.op4_input_STB, 1);
    end
    bus.op4_BUSY = 1'b1;
    tick();
    chk("stb_fall", bus.op4_input_STB, 0);
    chk("omb_low", bus.op4_output_module_BUSY, 0);
    chk("ops_w0", {bus.op_b, bus.op_a}, w0);
    chk("ops_w1", {bus.op_d, bus.op_c}, w1);
  endtask

  task automatic run_op(input logic [31:0] w0, input logic [31:0] w1, input bit tmo,
                        input int lat, input int hold, input int bp,
                        input bit use_ovr, input logic [15:0] ovr);
    logic [15:0] exp_res;
    logic [15:0] held;
    int n;
    exp_res = use_ovr ? ovr : 16'(w0[15:0] + w0[31:16] + w1[15:0] + w1[31:16]);
    issue(w0, w1, hold);
    bus.result_BUSY = (bp > 0);
    if (!tmo) begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("early_res", bus.result_STB, 0);
      end
      bus.op4_result     = exp_res;
      bus.op4_output_STB = 1'b1;
      tick();
      bus.op4_output_STB = 1'b0;
      bus.op4_BUSY       = 1'b0;
      chk("res_stb", bus.result_STB, 1);
      chk("res_val", bus.result, exp_res);
      chk("res_err", bus.result_err, 0);
    end else begin
      n = 0;
      while (!bus.result_STB && n < TO + 10) begin
        tick();
        n++;
      end
      chk("tmo_latency", n, TO);
      chk("tmo_val", bus.result, 16'hFFFF);
      chk("tmo_err", bus.result_err, 1);
      stub_stuck = 1'b1;
    end
    chk("omb_high", bus.op4_output_module_BUSY, 1);
    held = bus.result;
    for (int i = 0; i < bp; i++) begin
      bus.in_STB  = 1'b1;
      bus.in_data = $urandom;
      tick();
      chk("bp_stb", bus.result_STB, 1);
      chk("bp_res", bus.result, held);
      chk("bp_in_busy", bus.in_BUSY, 1);
    end
    bus.in_STB      = 1'b0;
    bus.result_BUSY = 1'b0;
    tick();
    if (!tmo) done_m = done_m + 16'd1;
    chk("ret_stb", bus.result_STB, 0);
    chk("ret_in_busy", bus.in_BUSY, 0);
    chk("done_count", bus.done_count, done_m);
    chk("ops_kept", {bus.op_d, bus.op_c, bus.op_b, bus.op_a} == {w1, w0}, 1);
  endtask

  initial begin
    bus.in_data = '0; bus.in_STB = 1'b0; bus.op4_BUSY = 1'b0;
    bus.op4_result = '0; bus.op4_output_STB = 1'b0; bus.result_BUSY = 1'b0;
    tick(); tick();
    chk_reset_state();
    rst = 1'b1;
    tick();

    run_op(32'h4000_3C00, 32'h4400_4200, 1'b0, 2, 0, 0, 1'b1, 16'h4900);
    run_op($urandom, $urandom, 1'b0, 3, 0, 20, 1'b0, '0);
    run_op($urandom, $urandom, 1'b1, 0, 0, 2, 1'b0, '0);
    run_op($urandom, $urandom, 1'b0, 1, 3, 0, 1'b0, '0);
    run_op($urandom, $urandom, 1'b0, TO - 1, 0, 1, 1'b0, '0);

    // Abort a command while waiting for the result.
    issue($urandom, $urandom, 0);
    tick();
    rst = 1'b0;
    tick();
    bus.op4_BUSY = 1'b0;
    chk_reset_state();
    rst = 1'b1;
    done_m = '0;
    stub_stuck = 1'b0;
    tick();
    run_op($urandom, $urandom, 1'b0, 0, 0, 0, 1'b0, '0);

    for (int k = 0; k < 30; k++)
      run_op($urandom, $urandom, ($urandom_range(0, 4) == 0), int'($urandom_range(0, TO - 1)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 3)),
             1'b0, '0);

    force dut.done_q = 16'hFFFE;
    tick();
    release dut.done_q;
    tick();
    done_m = 16'hFFFE;
    chk("preload", bus.done_count, done_m);
    run_op($urandom, $urandom, 1'b0, 1, 0, 0, 1'b0, '0);
    run_op($urandom, $urandom, 1'b0, 1, 0, 0, 1'b0, '0);
    chk("wrap_zero", bus.done_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
